// File: rtl/ifu_fetch.sv
// Instruction-fetch unit: PC register, single-outstanding imem request port and a
// two-entry {pc, inst} buffer that feeds the IF/ID pipeline register.
module ifu_fetch #(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       INST_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h8000_0000,
  parameter logic [INST_W-1:0] NOP_INST = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              stall,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [INST_W-1:0] imem_rdata,
  output logic              if_valid,
  output logic [ADDR_W-1:0] if_pc,
  output logic [INST_W-1:0] if_inst
);

  localparam int unsigned DEPTH = 2;
  localparam int unsigned CNT_W = 2;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic              inflight_q, inflight_d;
  logic              kill_q, kill_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [ADDR_W-1:0] ent_pc_q [DEPTH];
  logic [ADDR_W-1:0] ent_pc_d [DEPTH];
  logic [INST_W-1:0] ent_inst_q [DEPTH];
  logic [INST_W-1:0] ent_inst_d [DEPTH];

  logic             handshake;
  logic             push;
  logic             pop;
  logic [CNT_W-1:0] cnt_after_pop;

  // One request outstanding at most; the buffer plus in-flight slot never exceeds two.
  assign imem_req  = ~rst_n & ~redirect_valid & ~inflight_q & (count_q < CNT_W'(DEPTH));
  assign imem_addr = pc_q;
  assign handshake = imem_req & imem_gnt;

  assign if_valid = (count_q != '0);
  assign if_pc    = if_valid ? ent_pc_q[0]   : '0;
  assign if_inst  = if_valid ? ent_inst_q[0] : NOP_INST;

  assign push = imem_rvalid & ~kill_q;
  assign pop  = if_valid & ~stall;

  always_comb begin
    pc_d          = pc_q;
    fetch_pc_d    = fetch_pc_q;
    inflight_d    = inflight_q;
    kill_d        = kill_q;
    count_d       = count_q;
    ent_pc_d      = ent_pc_q;
    ent_inst_d    = ent_inst_q;
    cnt_after_pop = count_q - CNT_W'(pop);

    if (redirect_valid) begin
      // A response still owed after this cycle belongs to the old path and must be dropped.
      pc_d       = redirect_pc & ~ADDR_W'(3);
      count_d    = '0;
      inflight_d = inflight_q & ~imem_rvalid;
      kill_d     = inflight_q & ~imem_rvalid;
    end else begin
      if (imem_rvalid) begin
        inflight_d = 1'b0;
        kill_d     = 1'b0;
      end
      if (handshake) begin
        inflight_d = 1'b1;
        fetch_pc_d = pc_q;
        pc_d       = pc_q + ADDR_W'(4);
      end
      if (pop) begin
        ent_pc_d[0]   = ent_pc_q[1];
        ent_inst_d[0] = ent_inst_q[1];
      end
      if (push) begin
        ent_pc_d[cnt_after_pop[0]]   = fetch_pc_q;
        ent_inst_d[cnt_after_pop[0]] = imem_rdata;
      end
      count_d = cnt_after_pop + CNT_W'(push);
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      pc_q       <= RESET_PC;
      fetch_pc_q <= '0;
      inflight_q <= 1'b0;
      kill_q     <= 1'b0;
      count_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_pc_q[i]   <= '0;
        ent_inst_q[i] <= NOP_INST;
      end
    end else begin
      pc_q       <= pc_d;
      fetch_pc_q <= fetch_pc_d;
      inflight_q <= inflight_d;
      kill_q     <= kill_d;
      count_q    <= count_d;
      ent_pc_q   <= ent_pc_d;
      ent_inst_q <= ent_inst_d;
    end
  end

  assert property (@(posedge clk) disable iff (rst_n) count_q <= CNT_W'(DEPTH));

endmodule

// File: tb/tb_ifu_fetch.sv
// Scoreboard bench for ifu_fetch: a behavioural imem drives responses and the
// expected {pc, inst} stream is queued as responses are returned.
module tb_ifu_fetch;

  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned INST_W   = 32;
  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [31:0] KEY      = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;

  ifu_fetch #(
    .ADDR_W(ADDR_W), .INST_W(INST_W), .RESET_PC(RESET_PC), .NOP_INST(NOP)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .stall(stall),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] q_pc[$];
  logic [31:0] q_inst[$];
  logic [31:0] exp_pc, resp_addr, redir_target;
  logic [31:0] last_pc, last_inst, last_addr, last_hs_addr, a0;
  bit pend, stale, stall_en, gnt_en, redir_now, redir_on_rv;
  bit last_valid, last_req, last_hs, last_rd, seen;
  int lat, cd, hs_cnt;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive memory/control at negedge, check, then advance the model at posedge.
  task automatic cycle();
    bit rv, rd, hs;
    @(negedge clk);
    rv             = pend && (cd == 0);
    rd             = redir_now || (redir_on_rv && rv);
    redir_now      = 1'b0;
    imem_rvalid    = rv;
    imem_rdata     = rv ? (resp_addr ^ KEY) : 32'h0;
    redirect_valid = rd;
    redirect_pc    = redir_target;
    stall          = stall_en;
    imem_gnt       = 1'b0;
    #1;
    chk("imem_req", imem_req, !rd && !pend && (q_pc.size() < 2));
    if (imem_req) chk("imem_addr", imem_addr, exp_pc);
    chk("if_valid", if_valid, q_pc.size() != 0);
    if (q_pc.size() != 0) begin
      chk("if_pc", if_pc, q_pc[0]);
      chk("if_inst", if_inst, q_inst[0]);
    end else begin
      chk("bubble_pc", if_pc, 0);
      chk("bubble_inst", if_inst, NOP);
    end
    last_valid = if_valid; last_pc = if_pc; last_inst = if_inst;
    last_req = imem_req; last_addr = imem_addr; last_rd = rd;
    hs       = imem_req && gnt_en && !rd;
    imem_gnt = hs;
    last_hs  = hs;
    if (hs) last_hs_addr = imem_addr;
    @(posedge clk);
    if (rd) begin
      q_pc.delete(); q_inst.delete();
    end else if (q_pc.size() != 0 && !stall_en) begin
      void'(q_pc.pop_front()); void'(q_inst.pop_front());
    end
    if (rd && pend && !rv) stale = 1'b1;
    if (rv) begin
      if (stale) stale = 1'b0;
      else if (!rd) begin
        q_pc.push_back(resp_addr);
        q_inst.push_back(resp_addr ^ KEY);
      end
      pend = 1'b0;
    end else if (pend) cd--;
    if (rd) exp_pc = redir_target & ~32'h3;
    if (hs) begin
      pend = 1'b1; cd = lat - 1; resp_addr = exp_pc;
      exp_pc = exp_pc + 32'd4; hs_cnt++;
    end
  endtask

  task automatic reset_assert(input int offset);
    @(negedge clk);
    #(offset);
    rst_n = 1'b1;
    redirect_valid = 1'b0; stall = 1'b0; imem_gnt = 1'b0;
    imem_rvalid = 1'b0; imem_rdata = '0; redirect_pc = '0;
    q_pc.delete(); q_inst.delete();
    pend = 0; stale = 0; exp_pc = RESET_PC; hs_cnt = 0;
    redir_now = 0; redir_on_rv = 0; stall_en = 0;
    #1;
    chk("rst_req", imem_req, 0);
    chk("rst_valid", if_valid, 0);
    chk("rst_pc", if_pc, 0);
    chk("rst_inst", if_inst, NOP);
    chk("rst_addr", imem_addr, RESET_PC);
    @(negedge clk);
    rst_n = 1'b0;
  endtask

  task automatic run_until_valid(input string tag);
    seen = 0;
    for (int i = 0; i < 30 && !seen; i++) begin
      cycle();
      seen = last_valid;
    end
    if (!seen) chk({tag, "_timeout"}, 0, 1);
  endtask

  task automatic run_until_hs(input string tag);
    seen = 0;
    for (int i = 0; i < 30 && !seen; i++) begin
      cycle();
      seen = last_hs;
    end
    if (!seen) chk({tag, "_timeout"}, 0, 1);
  endtask

  initial begin
    rst_n = 1'b0; redirect_valid = 0; redirect_pc = '0; stall = 0;
    imem_gnt = 0; imem_rvalid = 0; imem_rdata = '0;
    lat = 1; gnt_en = 1; redir_target = '0; cd = 0;

    // Free-running memory
    reset_assert(0);
    run_until_valid("first");
    chk("first_pc", last_pc, RESET_PC);
    chk("first_inst", last_inst, RESET_PC ^ KEY);
    repeat (12) cycle();

    // Stall from the first valid instruction
    reset_assert(0);
    stall_en = 1;
    run_until_valid("stall_first");
    repeat (4) cycle();
    chk("stall_pc", last_pc, RESET_PC);
    chk("stall_reqs", hs_cnt, 2);
    stall_en = 0;
    cycle();
    chk("release0", last_pc, RESET_PC);
    cycle();
    chk("release1_valid", last_valid, 1);
    chk("release1_pc", last_pc, RESET_PC + 32'd4);
    repeat (6) cycle();

    // Redirect while a slow response is in flight
    lat = 3;
    run_until_hs("slow_hs");
    redir_target = 32'h8000_1003;
    redir_now = 1;
    cycle();
    run_until_valid("redir_a");
    chk("redir_head", last_pc, 32'h8000_1000);
    chk("redir_inst", last_inst, 32'h8000_1000 ^ KEY);
    run_until_valid("redir_b");
    chk("redir_next", last_pc, 32'h8000_1004);
    repeat (4) cycle();

    // Redirect coinciding with rvalid
    lat = 1;
    redir_target = 32'h8000_3000;
    redir_on_rv = 1;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      cycle();
      seen = last_rd;
    end
    redir_on_rv = 0;
    chk("rv_redir_seen", seen, 1);
    cycle();
    chk("rv_redir_req", last_req, 1);
    chk("rv_redir_addr", last_addr, 32'h8000_3000);
    repeat (6) cycle();

    // Grant withheld, then redirect while waiting
    gnt_en = 0;
    repeat (4) cycle();
    a0 = last_addr;
    repeat (4) begin
      cycle();
      chk("hold_req", last_req, 1);
      chk("hold_addr", last_addr, a0);
    end
    redir_target = 32'h8000_2000;
    redir_now = 1;
    cycle();
    cycle();
    chk("wait_redir_req", last_req, 1);
    chk("wait_redir_addr", last_addr, 32'h8000_2000);
    gnt_en = 1;
    repeat (6) cycle();

    // Address wrap
    redir_target = 32'hFFFF_FFFE;
    redir_now = 1;
    cycle();
    run_until_hs("wrap_a");
    chk("wrap_top", last_hs_addr, 32'hFFFF_FFFC);
    run_until_hs("wrap_b");
    chk("wrap_zero", last_hs_addr, 32'h0000_0000);
    repeat (4) cycle();

    // Asynchronous reset while a request is outstanding
    lat = 3;
    run_until_hs("mid_hs");
    reset_assert(2);
    lat = 1;
    run_until_valid("post_rst");
    chk("post_rst_pc", last_pc, RESET_PC);
    repeat (4) cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
